// File: rtl/id_authentication.sv
// ---------------------------------------------------------------------------
// id_authentication
//
// First login stage. It collects a 4-digit user ID from the debounced keypad.
// A fixed guest ID is recognised without touching the ID ROM. Any other ID is
// searched linearly through ROM entries 0..NUM_IDS-1. The result (matchedID,
// ID_internal, isGuest) is held for the password stage until that stage
// pulses logout.
//
// Optional lockout: define ID_LOCKOUT_EN to enable it. Three consecutive
// rejected IDs then lock the keypad for LOCK_CYCLES clock cycles.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   UserLoad     single-cycle digit strobe (already debounced)
//   UserDigit    digit value, sampled when UserLoad=1
//   logout       single-cycle pulse from the password stage; return to idle
//   rom_addr     registered ID ROM address
//   rom_data     ID ROM data, valid one cycle after rom_addr changes
//   matchedID    level: ID accepted
//   ID_internal  matched ROM index, 3'd7 for the guest
//   isGuest      level: guest ID accepted
//   mismatch     one-cycle pulse: ID rejected
//   digit_cnt    digits entered so far (0..4)
//   locked       lockout active (tied low without ID_LOCKOUT_EN)
// ---------------------------------------------------------------------------
module id_authentication #(
`ifdef ID_LOCKOUT_EN
    parameter logic [31:0] LOCK_CYCLES = 32'd250000000,
`endif
    parameter int unsigned NUM_IDS  = 7,
    parameter logic [15:0] GUEST_ID = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        UserLoad,
    input  logic [3:0]  UserDigit,
    input  logic        logout,
    output logic [2:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        matchedID,
    output logic [2:0]  ID_internal,
    output logic        isGuest,
    output logic        mismatch,
    output logic [2:0]  digit_cnt,
    output logic        locked
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        S_ADDR  = 3'd2,
        S_CMP   = 3'd3,
        MATCHED = 3'd4,
        FAIL    = 3'd5
`ifdef ID_LOCKOUT_EN
       ,LOCKED  = 3'd6
`endif
    } state_t;

    localparam logic [2:0] LAST_ADDR = 3'(NUM_IDS - 1);

    state_t      state_reg;
    logic [15:0] id_buf_reg;

`ifdef ID_LOCKOUT_EN
    logic [1:0]  fail_cnt_reg;
    logic [31:0] lock_cnt_reg;
`else
    assign locked = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            id_buf_reg   <= 16'd0;
            digit_cnt    <= 3'd0;
            rom_addr     <= 3'd0;
            matchedID    <= 1'b0;
            ID_internal  <= 3'd0;
            isGuest      <= 1'b0;
            mismatch     <= 1'b0;
`ifdef ID_LOCKOUT_EN
            locked       <= 1'b0;
            fail_cnt_reg <= 2'd0;
            lock_cnt_reg <= 32'd0;
`endif
        end else begin
            // mismatch is a single-cycle pulse; only the FAIL entry raises it
            mismatch <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (UserLoad) begin
                        // Shift left so the first digit ends in the MSB nibble
                        id_buf_reg <= {id_buf_reg[11:0], UserDigit};
                        digit_cnt  <= digit_cnt + 3'd1;
                        if (digit_cnt == 3'd3) begin
                            state_reg <= CHECK;
                        end
                    end
                end

                CHECK: begin
                    // Guest is decided before the ROM, so a ROM entry equal
                    // to GUEST_ID can never be reported as a ROM match.
                    if (id_buf_reg == GUEST_ID) begin
                        state_reg   <= MATCHED;
                        matchedID   <= 1'b1;
                        isGuest     <= 1'b1;
                        ID_internal <= 3'd7;
`ifdef ID_LOCKOUT_EN
                        fail_cnt_reg <= 2'd0;
`endif
                    end else begin
                        rom_addr  <= 3'd0;
                        state_reg <= S_ADDR;
                    end
                end

                // Address is held one cycle so the synchronous ROM output
                // reflects it when S_CMP samples rom_data.
                S_ADDR: begin
                    state_reg <= S_CMP;
                end

                S_CMP: begin
                    if (rom_data == id_buf_reg) begin
                        // Ascending scan: lowest duplicate index wins
                        state_reg   <= MATCHED;
                        matchedID   <= 1'b1;
                        isGuest     <= 1'b0;
                        ID_internal <= rom_addr;
`ifdef ID_LOCKOUT_EN
                        fail_cnt_reg <= 2'd0;
`endif
                    end else if (rom_addr == LAST_ADDR) begin
                        state_reg  <= FAIL;
                        mismatch   <= 1'b1;
                        id_buf_reg <= 16'd0;
                        digit_cnt  <= 3'd0;
                        rom_addr   <= 3'd0;
`ifdef ID_LOCKOUT_EN
                        fail_cnt_reg <= fail_cnt_reg + 2'd1;
`endif
                    end else begin
                        rom_addr  <= rom_addr + 3'd1;
                        state_reg <= S_ADDR;
                    end
                end

                MATCHED: begin
                    // logout wins over a simultaneous digit, which is dropped
                    if (logout) begin
                        state_reg   <= IDLE;
                        matchedID   <= 1'b0;
                        isGuest     <= 1'b0;
                        ID_internal <= 3'd0;
                        id_buf_reg  <= 16'd0;
                        digit_cnt   <= 3'd0;
                        rom_addr    <= 3'd0;
`ifdef ID_LOCKOUT_EN
                        fail_cnt_reg <= 2'd0;
`endif
                    end
                end

                FAIL: begin
`ifdef ID_LOCKOUT_EN
                    // fail_cnt_reg already counts the failure just reported
                    if (fail_cnt_reg == 2'd3) begin
                        state_reg    <= LOCKED;
                        locked       <= 1'b1;
                        lock_cnt_reg <= 32'd0;
                    end else begin
                        state_reg <= IDLE;
                    end
`else
                    state_reg <= IDLE;
`endif
                end

`ifdef ID_LOCKOUT_EN
                LOCKED: begin
                    // locked stays high for exactly LOCK_CYCLES cycles
                    if (lock_cnt_reg == LOCK_CYCLES - 32'd1) begin
                        state_reg    <= IDLE;
                        locked       <= 1'b0;
                        fail_cnt_reg <= 2'd0;
                    end else begin
                        lock_cnt_reg <= lock_cnt_reg + 32'd1;
                    end
                end
`endif

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_authentication.sv
// ---------------------------------------------------------------------------
// tb_id_authentication
//
// Self-checking bench for id_authentication. The reference model resolves an
// ID directly: guest, lowest matching ROM index, or rejection. The expected
// decision latency is computed from the search cost of two cycles per
// entry. The ROM is modelled with a registered read. Digits and logout
// pulses are injected where they must be ignored. Define ID_LOCKOUT_EN to
// also exercise the lockout path with LOCK_CYCLES=20.
// ---------------------------------------------------------------------------
module tb_id_authentication;

    localparam int          NUM_IDS  = 7;
    localparam logic [15:0] GUEST_ID = 16'hFFFF;
`ifdef ID_LOCKOUT_EN
    localparam int          LOCK_CYCLES = 20;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        UserLoad;
    logic [3:0]  UserDigit;
    logic        logout;
    logic [2:0]  rom_addr;
    logic [15:0] rom_data;
    logic        matchedID;
    logic [2:0]  ID_internal;
    logic        isGuest;
    logic        mismatch;
    logic [2:0]  digit_cnt;
    logic        locked;

    logic [15:0] rom [8];
    int checks = 0;
    int errors = 0;
    int fail_run = 0;

    always #5 clk = ~clk;

    // Synchronous ROM: data follows the address one cycle later
    always @(posedge clk) rom_data <= rom[rom_addr];

    id_authentication #(
`ifdef ID_LOCKOUT_EN
        .LOCK_CYCLES(32'(LOCK_CYCLES)),
`endif
        .NUM_IDS(NUM_IDS),
        .GUEST_ID(GUEST_ID)
    ) dut (
        .clk(clk),
        .rst(rst),
        .UserLoad(UserLoad),
        .UserDigit(UserDigit),
        .logout(logout),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .matchedID(matchedID),
        .ID_internal(ID_internal),
        .isGuest(isGuest),
        .mismatch(mismatch),
        .digit_cnt(digit_cnt),
        .locked(locked)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // -1 guest, 0..NUM_IDS-1 lowest matching index, -2 rejected
    function automatic int lookup(input logic [15:0] id);
        if (id == GUEST_ID) return -1;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (rom[i] == id) return i;
        end
        return -2;
    endfunction

    task automatic check_all_clear(input string tag);
        check_eq({tag, "_matched"}, 32'(matchedID), 32'd0);
        check_eq({tag, "_guest"}, 32'(isGuest), 32'd0);
        check_eq({tag, "_idint"}, 32'(ID_internal), 32'd0);
        check_eq({tag, "_mismatch"}, 32'(mismatch), 32'd0);
        check_eq({tag, "_digits"}, 32'(digit_cnt), 32'd0);
        check_eq({tag, "_addr"}, 32'(rom_addr), 32'd0);
        check_eq({tag, "_locked"}, 32'(locked), 32'd0);
    endtask

    task automatic enter_digits(input logic [15:0] id);
        for (int d = 0; d < 4; d++) begin
            if ($urandom_range(0, 1) == 1) begin
                // logout in IDLE must not disturb partial entry
                UserLoad = 1'b0;
                logout   = 1'b1;
                tick();
                logout   = 1'b0;
                check_eq("idle_logout_cnt", 32'(digit_cnt), 32'(d));
                check_eq("idle_matched", 32'(matchedID), 32'd0);
            end
            UserLoad  = 1'b1;
            UserDigit = id[15-4*d -: 4];
            tick();
            UserLoad  = 1'b0;
            check_eq("digit_cnt", 32'(digit_cnt), 32'(d + 1));
        end
    endtask

    task automatic login(input logic [15:0] id);
        int res;
        int lat;
        res = lookup(id);
        lat = (res == -1) ? 2 : (res >= 0) ? 2 * res + 3 : 2 * NUM_IDS + 1;
        enter_digits(id);

        // Search phase: stray digits and logout pulses must be ignored
        for (int k = 1; k < lat; k++) begin
            UserLoad  = ($urandom_range(0, 2) == 0);
            UserDigit = 4'($urandom);
            logout    = ($urandom_range(0, 2) == 0);
            tick();
        end
        UserLoad = 1'b0;
        logout   = 1'b0;
        if (res != -1) begin
            check_eq("pre_matched", 32'(matchedID), 32'd0);
            check_eq("pre_mismatch", 32'(mismatch), 32'd0);
            check_eq("search_digits", 32'(digit_cnt), 32'd4);
            check_eq("last_addr", 32'(rom_addr), 32'((res >= 0) ? res : NUM_IDS - 1));
        end
        tick();

        if (res != -2) begin
            check_eq("matched", 32'(matchedID), 32'd1);
            check_eq("id_internal", 32'(ID_internal), 32'((res == -1) ? 7 : res));
            check_eq("is_guest", 32'(isGuest), 32'(res == -1));
            check_eq("no_mismatch", 32'(mismatch), 32'd0);
            if (res == -1) check_eq("guest_addr", 32'(rom_addr), 32'd0);
            fail_run = 0;
            // Held through a few cycles of ignored key presses
            for (int h = 0; h < $urandom_range(1, 4); h++) begin
                UserLoad  = $urandom_range(0, 1) == 1;
                UserDigit = 4'($urandom);
                tick();
            end
            UserLoad = 1'b0;
            check_eq("held_matched", 32'(matchedID), 32'd1);
            check_eq("held_idint", 32'(ID_internal), 32'((res == -1) ? 7 : res));
            check_eq("held_digits", 32'(digit_cnt), 32'd4);
            // logout and a digit together: logout wins, digit dropped
            logout    = 1'b1;
            UserLoad  = 1'b1;
            UserDigit = 4'($urandom);
            tick();
            logout   = 1'b0;
            UserLoad = 1'b0;
            check_all_clear("logout");
        end else begin
            check_eq("mismatch", 32'(mismatch), 32'd1);
            check_eq("fail_matched", 32'(matchedID), 32'd0);
            fail_run++;
            // A digit during the FAIL cycle is ignored
            UserLoad  = 1'b1;
            UserDigit = 4'($urandom);
            tick();
            UserLoad = 1'b0;
            check_eq("mismatch_pulse", 32'(mismatch), 32'd0);
            check_eq("fail_digits", 32'(digit_cnt), 32'd0);
`ifdef ID_LOCKOUT_EN
            if (fail_run == 3) begin
                check_eq("lock_on", 32'(locked), 32'd1);
                for (int c = 1; c < LOCK_CYCLES; c++) begin
                    UserLoad  = 1'b1;
                    UserDigit = 4'($urandom);
                    tick();
                end
                UserLoad = 1'b0;
                check_eq("lock_hold", 32'(locked), 32'd1);
                check_eq("lock_digits", 32'(digit_cnt), 32'd0);
                tick();
                check_eq("lock_off", 32'(locked), 32'd0);
                fail_run = 0;
            end else begin
                check_eq("no_lock", 32'(locked), 32'd0);
            end
`else
            check_eq("no_lock", 32'(locked), 32'd0);
`endif
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] id;
        rst       = 1'b0;
        UserLoad  = 1'b0;
        UserDigit = 4'd0;
        logout    = 1'b0;

        // ROM: index 1 holds the guest value (never reachable), index 2 the
        // reference ID, index 5 duplicates index 3, index 7 lies beyond
        // NUM_IDS. Random entries use top nibble 4..7 to avoid 1234/9999.
        for (int i = 0; i < 8; i++) rom[i] = 16'(($urandom & 32'h3FFF) | 32'h4000);
        rom[1] = 16'hFFFF;
        rom[2] = 16'h1234;
        rom[5] = rom[3];
        rom[7] = 16'h8888;

        repeat (2) @(posedge clk);
        #1;
        check_all_clear("reset");
        rst = 1'b1;
        tick();

        login(16'h1234);
        login(16'hFFFF);
        login(16'h9999);
        login(16'h8888);
        login(rom[3]);
        login(rom[6]);

        // Asynchronous reset in the middle of a search at rom_addr=3
        enter_digits(16'h9999);
        repeat (7) tick();
        check_eq("mid_addr", 32'(rom_addr), 32'd3);
        check_eq("mid_digits", 32'(digit_cnt), 32'd4);
        #2;
        rst = 1'b0;
        #1;
        check_all_clear("async_rst");
        tick();
        rst = 1'b1;
        fail_run = 0;
        tick();
        login(16'h1234);

        // Three consecutive rejections, then a valid login
        login(16'h9999);
        login(16'h9999);
        login(16'h9999);
        login(16'h1234);

        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(0, 3))
                0: id = rom[$urandom_range(0, 7)];
                1: id = GUEST_ID;
                2: id = 16'($urandom);
                default: id = 16'(($urandom & 32'h0FFF) | 32'h9000);
            endcase
            login(id);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
